// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 4-digit seven-segment scan driver for a 0..15 count
// Value is latched only at frame boundaries; tens digit uses leading-zero blanking.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] val,
   input  logic       hold,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam logic [19:0] PRESCALE_MAX = 20'(REFRESH_DIV - 1);
   localparam logic [6:0]  SEG_OFF      = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]  AN_OFF       = ACTIVE_LOW ? 4'hF  : 4'h0;

   logic [19:0] prescaler;
   logic        tick;
   logic [1:0]  dig;
   logic [3:0]  shadow;
   logic        tens;
   logic [3:0]  ones;
   logic [6:0]  seg_hi;
   logic [3:0]  an_hi;
   logic [6:0]  seg_d;
   logic [3:0]  an_d;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] code;
      case (d)
         4'd0:    code = 7'b0111111;
         4'd1:    code = 7'b0000110;
         4'd2:    code = 7'b1011011;
         4'd3:    code = 7'b1001111;
         4'd4:    code = 7'b1100110;
         4'd5:    code = 7'b1101101;
         4'd6:    code = 7'b1111101;
         4'd7:    code = 7'b0000111;
         4'd8:    code = 7'b1111111;
         4'd9:    code = 7'b1101111;
         default: code = 7'b0000000;
      endcase
      return code;
   endfunction

   assign tick = (prescaler == PRESCALE_MAX);

   // Scan timing and frame latch; shadow only moves on the last tick of a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         dig       <= '0;
         shadow    <= '0;
      end else if (tick) begin
         prescaler <= '0;
         dig       <= dig + 2'd1;
         if (dig == 2'd3 && !hold) begin
            shadow <= val;
         end
      end else begin
         prescaler <= prescaler + 20'd1;
      end
   end

   always_comb begin
      tens = (shadow >= 4'd10);
      ones = tens ? (shadow - 4'd10) : shadow;
   end

   // Slots 2 and 3 stay dark so the duty cycle matches a full 4-digit panel.
   always_comb begin
      seg_hi = '0;
      an_hi  = '0;
      case (dig)
         2'd0: begin
            seg_hi = seg_code(ones);
            an_hi  = 4'b0001;
         end
         2'd1: begin
            if (tens) begin
               seg_hi = seg_code(4'd1);
               an_hi  = 4'b0010;
            end
         end
         default: begin
            seg_hi = '0;
            an_hi  = '0;
         end
      endcase
      seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
      an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the 4-bit LED counter value.
- Takes the 4-bit count (0..15) and converts it to two decimal digits, tens and ones.
- Drives a 4-digit multiplexed seven-segment display with a refresh scan and leading-zero blanking.
- Samples the input value only at frame boundaries, so a display scan never shows a mix of old and new values.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^20.
- ACTIVE_LOW, 1, 1 = seg and an are active-low (lit/enabled = 0); 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- val  input  4  unsigned count value from the counter stage, 0..15.
- hold  input  1  1 = freeze the displayed value (suppress frame latch).
- seg  output  7  segment drive {g,f,e,d,c,b,a}, registered.
- an  output  4  digit enables, an[0] = ones digit, registered.

Behaviour:
- Reset (reset=0), asynchronous, takes effect immediately regardless of clk:
  - prescaler=0, dig=0, shadow=0.
  - seg = all segments off (7'h7F when ACTIVE_LOW=1).
  - an = all digits off (4'b1111 when ACTIVE_LOW=1).
- Reset release: reset is released synchronously by the system; the block counts from the first rising clk edge with reset=1.
- Prescaler:
  - 20-bit counter 0..REFRESH_DIV-1; wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1), one cycle wide.
- Digit index dig[1:0]:
  - Advances on tick: 0->1->2->3->0.
  - One frame = 4*REFRESH_DIV cycles.
- Frame latch:
  - On tick with dig==3 and hold==0: shadow <= val.
  - On tick with dig==3 and hold==1: shadow unchanged.
  - val and hold are ignored at all other cycles; they need not be stable between frame boundaries.
  - New value appears on the outputs with dig==0 of the next frame, one cycle after the boundary edge.
- BCD conversion, combinational on shadow:
  - tens = (shadow >= 10).
  - ones = tens ? shadow-10 : shadow.
  - Result range: ones 0..9, tens 0..1.
- Digit content by dig:
  - dig 0: ones digit, always enabled; "0" is displayed.
  - dig 1: tens digit; enabled only if tens==1 (leading-zero blanking), otherwise anode off and segs off.
  - dig 2, 3: always blank (anode off, segs off); the slots are kept so duty cycle matches a 4-digit panel.
- Output register:
  - Every clk edge (reset=1), seg/an load the decode of the current dig and shadow.
  - Output latency is one cycle after a dig or shadow change.
  - Exactly one an bit is active, or none; never two.
- Segment codes (active-high, gfedcba):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - ACTIVE_LOW=1 inverts both seg and an.
- Boundary conditions:
  - val 9->10: tens digit appears at the next frame.
  - val 15->0 wrap: display shows "0" with the tens digit blanked.
  - hold asserted on the same cycle as the latch tick: freeze wins, shadow unchanged.
  - reset mid-frame: everything cleared; scan restarts at dig 0 with shadow 0.
- Width rule: prescaler compare uses full 20-bit width; REFRESH_DIV outside the legal range is not supported.

Test Plan:
Bench runs with REFRESH_DIV=4 and ACTIVE_LOW=1.
1. Hold reset=0 for 3 cycles, then drive reset=0 asynchronously mid-frame -> seg=7'h7F and an=4'b1111 immediately, without waiting for a clk edge; after release, dig0 shows seg=7'h40 ("0"), an=4'b1110, and dig1..3 show an=4'b1111.
2. Set val=5 before the first frame boundary -> from the next frame, dig0 slot shows seg=7'h12, an=4'b1110; dig1 slot shows an=4'b1111, seg=7'h7F; each slot lasts exactly 4 cycles and a frame is 16 cycles.
3. Set val=13 -> next frame: dig0 shows seg=7'h30 ("3"), an=4'b1110; dig1 shows seg=7'h79 ("1"), an=4'b1101.
4. Change val 13->7 at cycle 6 of a frame -> the rest of that frame still shows "13"; the following frame shows dig0 seg=7'h78 ("7") with the tens digit blank.
5. Display val=12, then set hold=1 and change val to 2 -> "12" persists for 3 or more frames; after hold=0, "2" appears at the next frame with the tens digit blanked.
6. Drive val=15 then val=0 across two boundaries, with hold asserted exactly on the latch tick once -> display goes "15" -> "0"; the frame with hold on the tick keeps its prior value.
